// File: rtl/iter_shift_unit.sv
// Multi-cycle 32-bit shifter: one power-of-two stage (1,2,4,8,16) per cycle,
// fixed 5-cycle busy window, one-cycle done pulse, held result.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic [2:0]       k_q, k_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] stage_out;

  // Single shared stage: shift by 2^k with the fill selected by op.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] data,
    input logic [1:0]       sop,
    input logic [2:0]       k
  );
    logic [SHW-1:0] amt;
    amt = 5'd1 << k;
    case (sop)
      2'b00:   stage_shift = data << amt;
      2'b01:   stage_shift = data >> amt;
      2'b10:   stage_shift = $unsigned($signed(data) >>> amt);
      default: stage_shift = data;
    endcase
  endfunction

  // Stage datapath: apply the 2^k shift only when the latched shamt bit is set.
  always_comb begin
    stage_out = work_q;
    if (shamt_q[k_q]) begin
      stage_out = stage_shift(work_q, op_q, k_q);
    end else begin
      stage_out = work_q;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    op_d     = op_q;
    k_d      = k_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          work_d  = in_data;
          shamt_d = shamt;
          op_d    = op;
          k_d     = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        if (k_q == 3'd4) begin
          result_d = stage_out;
          k_d      = 3'd0;
          state_d  = DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      work_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      shamt_q  <= {SHW{1'b0}};
      op_q     <= 2'b00;
      k_q      <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      k_q      <= k_d;
      busy_q   <= (state_d == SHIFT);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle 32-bit shifter for the processor's execute stage. Each cycle it applies at most one power-of-two shift stage (1, 2, 4, 8, 16) to a working register, so one small stage datapath is reused instead of a full combinational barrel shifter.
- Supports sll, srl and sra. Uses a start/busy/done handshake toward the ALU control, with a fixed latency.

Parameters:
- WIDTH, 32, data width; only 32 is supported.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when not busy.
- in_data  input  32  operand to shift.
- shamt  input  5  shift amount, 0..31.
- op  input  2  00 = sll, 01 = srl, 10 = sra, 11 = pass-through.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  32  final shifted value; held until the next completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset, asserted at any time including mid-operation:
  - state = IDLE, busy = 0, done = 0, result = 0.
  - Working register, latched shamt/op and stage counter k all cleared.
  - Any in-flight operation is discarded; no done is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, start = 1 at a clock edge:
  - Latch in_data into the working register; latch shamt and op; set k = 0.
  - Go to SHIFT.
- IDLE or DONE, start = 0: go to or stay in IDLE.
- DONE lasts exactly one cycle. done = 1 only in DONE. A start seen in DONE is accepted (back-to-back operation).
- SHIFT, each edge:
  - If latched shamt[k] = 1, shift the working register by 2^k. Otherwise hold it.
  - Fill for sll and srl: zeros.
  - Fill for sra: the working register's bit 31, which always equals the original operand's bit 31.
  - op = 11: the register is never modified, whatever the shamt.
  - Then k = k + 1.
  - On the edge where k = 4 is processed, load result with the stage-4 output and go to DONE.
- Latency is fixed and independent of shamt and op:
  - start high in cycle N.
  - busy high in cycles N+1..N+5.
  - done high and result valid in cycle N+6.
- busy = 1 exactly in SHIFT. A start while busy is ignored and not queued; the inputs are not resampled.
- in_data, shamt and op may change freely after the accepting edge without affecting the operation.
- result changes only on the edge entering DONE. It is stable in all other cycles.
- Arithmetic rules:
  - shamt is 5 bits, so the maximum shift is 31. A shift of 32 or more is unrepresentable.
  - The working register is exactly 32 bits. Bits shifted out are discarded.

Test Plan:
- Reset release, then start with op = 10, in_data = 0x80000000, shamt = 31 → busy for 5 cycles; done in cycle N+6 with result = 0xFFFFFFFF.
- op = 01, in_data = 0x80000000, shamt = 31 → result = 0x00000001. Then op = 00, in_data = 0x00000001, shamt = 31 → result = 0x80000000.
- op = 10, in_data = 0x7000F000, shamt = 0 → result = 0x7000F000, still with the 5-cycle busy window. Then op = 11, in_data = 0x12345678, shamt = 13 → result = 0x12345678.
- Start with op = 01, in_data = 0xF0000000, shamt = 4. Pulse start again at N+2 with in_data = 0xFFFFFFFF, op = 00, shamt = 0 → the second start is ignored; single done at N+6 with result = 0x0F000000.
- Back-to-back: start held high through the DONE cycle with op = 00, in_data = 0x00000003, shamt = 2 → the second op is accepted in the DONE cycle; second done 6 cycles later with result = 0x0000000C.
- Start op = 10, in_data = 0x80000000, shamt = 8. Assert reset asynchronously mid-cycle at N+3 → busy, done and result drop to 0 immediately; no done follows after release. A new start then completes normally.
